// File: rtl/xor16_frame_checksum_pkg.sv
// rtl/xor16_frame_checksum_pkg.sv - shared state encodings and parameter defaults for the frame checksum
package xor16_frame_checksum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_SEED      = 16'h0000;
    localparam int          DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/xor16_frame_checksum_xor_gate16.sv
// rtl/xor16_frame_checksum_xor_gate16.sv - 16-bit bitwise XOR stage feeding the accumulator
module xor16_frame_checksum_xor_gate16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor16_frame_checksum.sv
// rtl/xor16_frame_checksum.sv - framed 16-bit running XOR checksum with valid/ready in and held result out
module xor16_frame_checksum
    import xor16_frame_checksum_pkg::*;
#(
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             drop
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic             accept;
    logic             restart;
    logic             cnt_sat;
    logic [15:0]      acc_or_seed;
    logic [15:0]      acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;

    assign accept  = in_valid & in_ready;
    // A first beat always starts from SEED, even when it abandons a partial frame.
    assign restart = (state == ST_IDLE) | in_first;
    assign cnt_sat = (cnt == MAX_CNT);

    assign acc_or_seed = restart ? SEED : acc;
    assign cnt_next    = restart ? CNT_W'(1) : (cnt_sat ? cnt : cnt + 1'b1);
    assign err_next    = restart ? 1'b0 : (err | cnt_sat);

    xor16_frame_checksum_xor_gate16 u_xor (
        .a (acc_or_seed),
        .b (in_data),
        .y (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (state == ST_IDLE && !in_first) begin
                            drop <= 1'b1;
                        end else begin
                            drop <= in_first && (state == ST_ACCUM);
                            acc  <= acc_next;
                            cnt  <= cnt_next;
                            err  <= err_next;
                            if (in_last) begin
                                state     <= ST_HOLD;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_sum   <= acc_next;
                                out_count <= cnt_next;
                                out_err   <= err_next;
                            end else begin
                                state <= ST_ACCUM;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor16_frame_checksum.sv
// tb/tb_xor16_frame_checksum.sv - directed self-checking bench for xor16_frame_checksum
module tb_xor16_frame_checksum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic [8:0]  out_count;
    logic        out_err;
    logic        drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xor16_frame_checksum #(
        .SEED      (16'h0000),
        .MAX_WORDS (4),
        .CNT_W     (9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_err   (out_err),
        .drop      (drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] data, input logic first, input logic last);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_first = first;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
        check({tag, "_out_err"},   32'(out_err),   32'd0);
        check({tag, "_drop"},      32'(drop),      32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_rise", 32'(in_ready), 32'd1);

        // 1: three-word frame, consumer always ready
        out_ready = 1'b1;
        send(16'h1234, 1'b1, 1'b0);
        send(16'h00FF, 1'b0, 1'b0);
        send(16'hF0F0, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum",   32'(out_sum),   32'hE23B);
        check("t1_count", 32'(out_count), 32'd3);
        check("t1_err",   32'(out_err),   32'd0);
        check("t1_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(out_valid), 32'd0);
        check("t1_ready_back",      32'(in_ready),  32'd1);

        // 2: single-beat frame
        send(16'hA5A5, 1'b1, 1'b1);
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_sum",   32'(out_sum),   32'hA5A5);
        check("t2_count", 32'(out_count), 32'd1);
        @(negedge clk);

        // 3: consumer stalls for five cycles
        out_ready = 1'b0;
        send(16'h0001, 1'b1, 1'b0);
        send(16'h0002, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_sum",   32'(out_sum),   32'h0003);
            check("t3_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_released", 32'(out_valid), 32'd0);

        // 4: six words with MAX_WORDS=4
        for (int i = 1; i <= 6; i++)
            send(16'(i), i == 1, i == 6);
        @(negedge clk);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_err",   32'(out_err),   32'd1);
        check("t4_count", 32'(out_count), 32'd4);
        check("t4_sum",   32'(out_sum),   32'h0007);
        @(negedge clk);

        // 5a: stray beat in IDLE
        send(16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        check("t5a_drop",  32'(drop),      32'd1);
        check("t5a_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t5a_drop_pulse", 32'(drop), 32'd0);

        // 5b: new first abandons a partial frame
        send(16'hFFFF, 1'b1, 1'b0);
        send(16'h00AA, 1'b1, 1'b1);
        @(negedge clk);
        check("t5b_drop",  32'(drop),      32'd1);
        check("t5b_valid", 32'(out_valid), 32'd1);
        check("t5b_sum",   32'(out_sum),   32'h00AA);
        check("t5b_count", 32'(out_count), 32'd1);
        @(negedge clk);
        check("t5b_drop_pulse", 32'(drop), 32'd0);

        // 6: asynchronous reset mid-frame
        send(16'h1111, 1'b1, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_rise", 32'(in_ready), 32'd1);
        send(16'h0F0F, 1'b1, 1'b1);
        @(negedge clk);
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_sum",   32'(out_sum),   32'h0F0F);
        check("t6_count", 32'(out_count), 32'd1);
        check("t6_err",   32'(out_err),   32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
